// File: rtl/irq_controller.sv
// irq_controller: interrupt enable/flag registers, IME with EI delay,
// edge detection, priority selection and the CPU dispatch handshake.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   DL                  write data for IE / IF
//   Thingy_to_bot       IE write strobe (0xFFFF)
//   IF_wr               IF write strobe (0xFF0F)
//   IE_rd, IF_rd        read selects -> dout, dout_oe
//   irq_in              peripheral request levels (rising edge sets IF)
//   ei, di, m1          EI / DI executed, instruction boundary
//   int_pending         |(IE & IF), used for HALT wake
//   int_req             dispatch request to the sequencer
//   int_ack, vec_sample, vec_taken   dispatch handshake inputs
//   vector, vec_valid   dispatch vector and its valid flag
//
// Build option: define IRQ_DISPATCH_CANCEL_EN to resolve the vector at
// vec_sample (vector 0x00 with nothing cleared when nothing is pending);
// otherwise the index latched at int_ack is used.
module irq_controller #(
    parameter int unsigned NUM_IRQ  = 5,
    parameter logic [7:0]  VEC_BASE = 8'h40,
    parameter int unsigned VEC_STEP = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         DL,
    input  logic               Thingy_to_bot,
    input  logic               IF_wr,
    input  logic               IE_rd,
    input  logic               IF_rd,
    output logic [7:0]         dout,
    output logic               dout_oe,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ei,
    input  logic               di,
    input  logic               m1,
    output logic               int_pending,
    output logic               int_req,
    input  logic               int_ack,
    input  logic               vec_sample,
    output logic [7:0]         vector,
    output logic               vec_valid,
    input  logic               vec_taken
);
    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        VEC  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [7:0]         ie;
    logic [NUM_IRQ-1:0] if_q, if_n, irq_prev, pend;
    logic               ime, ime_n, ei_dly, ei_dly_n;
    logic [IDX_W-1:0]   top_idx, disp_idx;
    logic               top_found, disp_valid;
    logic [7:0]         vector_n, if_rd_val;
    logic               vec_valid_n, take_ack, take_sample;

    assign pend        = ie[NUM_IRQ-1:0] & if_q;
    assign int_pending = |pend;
    assign int_req     = ime & int_pending & (state == IDLE);
    assign dout_oe     = IE_rd | IF_rd;

    // Lowest set index wins.
    always_comb begin
        top_idx   = '0;
        top_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !top_found) begin
                top_idx   = IDX_W'(i);
                top_found = 1'b1;
            end
        end
    end

`ifdef IRQ_DISPATCH_CANCEL_EN
    assign disp_idx   = top_idx;
    assign disp_valid = top_found;
`else
    logic [IDX_W-1:0] lat_idx;

    always_ff @(posedge CLK) begin
        if (RESET)
            lat_idx <= '0;
        else if (take_ack)
            lat_idx <= top_idx;
    end

    assign disp_idx   = lat_idx;
    assign disp_valid = 1'b1;
`endif

    always_comb begin
        state_n     = state;
        take_ack    = 1'b0;
        take_sample = 1'b0;
        vector_n    = vector;
        vec_valid_n = vec_valid;
        case (state)
            IDLE: if (int_ack && int_req) begin
                state_n  = PUSH;
                take_ack = 1'b1;
            end
            PUSH: if (vec_sample) begin
                state_n     = VEC;
                take_sample = 1'b1;
                vec_valid_n = 1'b1;
                vector_n    = disp_valid
                            ? 8'(32'(VEC_BASE) + 32'(disp_idx) * VEC_STEP)
                            : '0;
            end
            VEC: if (vec_taken) begin
                state_n     = IDLE;
                vec_valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Promotion precedes the dispatch clear; di overrides everything.
    always_comb begin
        ime_n    = ime;
        ei_dly_n = ei_dly;
        if (m1 && ei_dly) begin
            ime_n    = 1'b1;
            ei_dly_n = 1'b0;
        end
        if (take_ack)
            ime_n = 1'b0;
        if (ei)
            ei_dly_n = 1'b1;
        if (di) begin
            ime_n    = 1'b0;
            ei_dly_n = 1'b0;
        end
    end

    // Write, then dispatch clear, then edge set: a new edge is never lost.
    always_comb begin
        if_n = IF_wr ? DL[NUM_IRQ-1:0] : if_q;
        if (take_sample && disp_valid)
            if_n[disp_idx] = 1'b0;
        if_n = if_n | (irq_in & ~irq_prev);
    end

    always_comb begin
        if_rd_val              = '1;
        if_rd_val[NUM_IRQ-1:0] = if_q;
        if (IE_rd)
            dout = ie;
        else if (IF_rd)
            dout = if_rd_val;
        else
            dout = '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            ie        <= '0;
            if_q      <= '0;
            irq_prev  <= '0;
            ime       <= 1'b0;
            ei_dly    <= 1'b0;
            vector    <= '0;
            vec_valid <= 1'b0;
        end else begin
            state     <= state_n;
            if (Thingy_to_bot)
                ie <= DL;
            if_q      <= if_n;
            irq_prev  <= irq_in;
            ime       <= ime_n;
            ei_dly    <= ei_dly_n;
            vector    <= vector_n;
            vec_valid <= vec_valid_n;
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the register rules.
module tb_irq_controller;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] DL = '0;
    logic       Thingy_to_bot = 1'b0, IF_wr = 1'b0, IE_rd = 1'b0, IF_rd = 1'b0;
    logic [7:0] dout;
    logic       dout_oe;
    logic [4:0] irq_in = '0;
    logic       ei = 1'b0, di = 1'b0, m1 = 1'b0;
    logic       int_pending, int_req;
    logic       int_ack = 1'b0, vec_sample = 1'b0, vec_taken = 1'b0;
    logic [7:0] vector;
    logic       vec_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state (plain integers).
    int m_ie = 0, m_if = 0, m_ime = 0, m_dly = 0, m_stage = 0;
    int m_lat = 0, m_vec = 0, m_valid = 0, m_prev = 0;

    irq_controller #(.NUM_IRQ(5), .VEC_BASE(8'h40), .VEC_STEP(8)) dut (
        .CLK(CLK), .RESET(RESET), .DL(DL), .Thingy_to_bot(Thingy_to_bot),
        .IF_wr(IF_wr), .IE_rd(IE_rd), .IF_rd(IF_rd), .dout(dout),
        .dout_oe(dout_oe), .irq_in(irq_in), .ei(ei), .di(di), .m1(m1),
        .int_pending(int_pending), .int_req(int_req), .int_ack(int_ack),
        .vec_sample(vec_sample), .vector(vector), .vec_valid(vec_valid),
        .vec_taken(vec_taken)
    );

    always #5 CLK = ~CLK;

    function automatic int lowest(input int v);
        for (int i = 0; i < 5; i++)
            if (((v >> i) & 1) != 0) return i;
        return -1;
    endfunction

    task automatic model_step();
        int pend, clr, nime, ndly, nif, idx;
        if (RESET) begin
            m_ie = 0; m_if = 0; m_ime = 0; m_dly = 0; m_stage = 0;
            m_lat = 0; m_vec = 0; m_valid = 0; m_prev = 0;
            return;
        end
        pend = m_ie & m_if & 31;
        clr  = -1;
        nime = m_ime;
        ndly = m_dly;
        if (m_stage == 0 && int_ack && m_ime != 0 && pend != 0) begin
            m_stage = 1;
            m_lat   = lowest(pend);
            nime    = 0;
        end else if (m_stage == 1 && vec_sample) begin
`ifdef IRQ_DISPATCH_CANCEL_EN
            idx = lowest(pend);
`else
            idx = m_lat;
`endif
            m_vec   = (idx < 0) ? 0 : 'h40 + 8 * idx;
            clr     = idx;
            m_valid = 1;
            m_stage = 2;
        end else if (m_stage == 2 && vec_taken) begin
            m_valid = 0;
            m_stage = 0;
        end
        if (m1 && m_dly != 0) begin
            if (!(m_stage == 1 && nime == 0 && m_ime != 0)) nime = 1;
            ndly = 0;
        end
        if (ei) ndly = 1;
        if (di) begin nime = 0; ndly = 0; end
        nif = IF_wr ? (int'(DL) & 31) : m_if;
        if (clr >= 0) nif = nif & ~(1 << clr);
        nif = nif | (int'(irq_in) & ~m_prev & 31);
        if (Thingy_to_bot) m_ie = int'(DL);
        m_if   = nif;
        m_prev = int'(irq_in);
        m_ime  = nime;
        m_dly  = ndly;
    endtask

    // One clock: model consumes the inputs seen by the edge, pulses then drop.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        Thingy_to_bot = 0; IF_wr = 0; ei = 0; di = 0; m1 = 0;
        int_ack = 0; vec_sample = 0; vec_taken = 0;
    endtask

    task automatic set_ime();
        di = 1; tick();
        ei = 1; tick();
        m1 = 1; tick();
    endtask

    task automatic test_reset();
        RESET = 1; tick(); tick();
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if (dout_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", dout_oe); end
        n_cmp++; if (int_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pend: got %b want 0", int_pending); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", int_req); end
        n_cmp++; if (vector !== 8'h00) begin n_bad++; $display("FAIL reset_vec: got %h want 00", vector); end
        n_cmp++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", vec_valid); end
        RESET = 0; tick();
        n_cmp++; if (int_pending !== 1'b0) begin n_bad++; $display("FAIL post_reset_pend: got %b want 0", int_pending); end
    endtask

    task automatic test_ie_if_rw();
        DL = 8'h1F; Thingy_to_bot = 1; tick();
        IE_rd = 1; #1;
        n_cmp++; if (dout !== 8'h1F) begin n_bad++; $display("FAIL ie_read: got %h want 1F", dout); end
        n_cmp++; if (dout_oe !== 1'b1) begin n_bad++; $display("FAIL ie_oe: got %b want 1", dout_oe); end
        IE_rd = 0;
        DL = 8'h00; IF_wr = 1; tick();
        IF_rd = 1; #1;
        n_cmp++; if (dout !== 8'hE0) begin n_bad++; $display("FAIL if_read: got %h want E0", dout); end
        IE_rd = 1; #1;
        n_cmp++; if (dout !== 8'h1F) begin n_bad++; $display("FAIL rd_priority: got %h want 1F", dout); end
        IE_rd = 0; IF_rd = 0; #1;
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL idle_dout: got %h want 00", dout); end
        n_cmp++; if (dout_oe !== 1'b0) begin n_bad++; $display("FAIL idle_oe: got %b want 0", dout_oe); end
    endtask

    task automatic test_priority();
        set_ime();
        irq_in = 5'b00101; tick();
        IF_rd = 1; #1;
        n_cmp++; if (dout !== 8'hE5) begin n_bad++; $display("FAIL prio_if: got %h want E5", dout); end
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL prio_req: got %b want 1", int_req); end
        IF_rd = 0;
        int_ack = 1; tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL prio_req_push: got %b want 0", int_req); end
        vec_sample = 1; tick();
        n_cmp++; if (vec_valid !== 1'b1) begin n_bad++; $display("FAIL prio_valid: got %b want 1", vec_valid); end
        n_cmp++; if (vector !== 8'h40) begin n_bad++; $display("FAIL prio_vector: got %h want 40", vector); end
        vec_taken = 1; tick();
        n_cmp++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL prio_taken: got %b want 0", vec_valid); end
        IF_rd = 1; #1;
        n_cmp++; if (dout !== 8'hE4) begin n_bad++; $display("FAIL prio_if_after: got %h want E4", dout); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL prio_ime_clr: got %b want 0", int_req); end
        n_cmp++; if (int_pending !== 1'b1) begin n_bad++; $display("FAIL prio_pend: got %b want 1", int_pending); end
        IF_rd = 0; irq_in = '0; tick();
    endtask

    task automatic test_ei_delay();
        ei = 1; m1 = 1; tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL ei_m1_same: got %b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL ei_no_m1: got %b want 0", int_req); end
        m1 = 1; tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL ei_second_m1: got %b want 1", int_req); end
        di = 1; tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL di_clear: got %b want 0", int_req); end
        ei = 1; di = 1; tick();
        m1 = 1; tick();
        m1 = 1; tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL ei_di_same: got %b want 0", int_req); end
    endtask

    task automatic test_race();
        set_ime();
        int_ack = 1; tick();
        vec_sample = 1; irq_in = 5'b00100; tick();
        n_cmp++; if (vector !== 8'h50) begin n_bad++; $display("FAIL race_vector: got %h want 50", vector); end
        vec_taken = 1; tick();
        IF_rd = 1; #1;
        n_cmp++; if (dout !== 8'hE4) begin n_bad++; $display("FAIL race_if: got %h want E4", dout); end
        IF_rd = 0; irq_in = '0; tick();
    endtask

    task automatic test_cancel();
        logic [7:0] want_vec, want_if;
`ifdef IRQ_DISPATCH_CANCEL_EN
        want_vec = 8'h00; want_if = 8'hE4;
`else
        want_vec = 8'h50; want_if = 8'hE0;
`endif
        DL = 8'h04; Thingy_to_bot = 1; tick();
        DL = 8'h04; IF_wr = 1; tick();
        set_ime();
        int_ack = 1; tick();
        DL = 8'h00; Thingy_to_bot = 1; tick();
        vec_sample = 1; tick();
        n_cmp++; if (vec_valid !== 1'b1) begin n_bad++; $display("FAIL cancel_valid: got %b want 1", vec_valid); end
        n_cmp++; if (vector !== want_vec) begin n_bad++; $display("FAIL cancel_vector: got %h want %h", vector, want_vec); end
        vec_taken = 1; tick();
        IF_rd = 1; #1;
        n_cmp++; if (dout !== want_if) begin n_bad++; $display("FAIL cancel_if: got %h want %h", dout, want_if); end
        IF_rd = 0;
    endtask

    task automatic test_reset_in_vec();
        DL = 8'h1F; Thingy_to_bot = 1; tick();
        DL = 8'h01; IF_wr = 1; tick();
        set_ime();
        int_ack = 1; tick();
        vec_sample = 1; tick();
        n_cmp++; if (vec_valid !== 1'b1) begin n_bad++; $display("FAIL rv_in_vec: got %b want 1", vec_valid); end
        RESET = 1; irq_in = 5'b00010; tick();
        n_cmp++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL rv_valid: got %b want 0", vec_valid); end
        n_cmp++; if (vector !== 8'h00) begin n_bad++; $display("FAIL rv_vector: got %h want 00", vector); end
        n_cmp++; if (int_pending !== 1'b0) begin n_bad++; $display("FAIL rv_pend: got %b want 0", int_pending); end
        IE_rd = 1; #1;
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rv_ie: got %h want 00", dout); end
        IE_rd = 0; IF_rd = 1; #1;
        n_cmp++; if (dout !== 8'hE0) begin n_bad++; $display("FAIL rv_if: got %h want E0", dout); end
        RESET = 0; tick();
        n_cmp++; if (dout !== 8'hE2) begin n_bad++; $display("FAIL rv_held_irq: got %h want E2", dout); end
        IF_rd = 0;
        DL = 8'h1F; Thingy_to_bot = 1; tick();
        n_cmp++; if (int_pending !== 1'b1) begin n_bad++; $display("FAIL rv_pend_after: got %b want 1", int_pending); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL rv_ime: got %b want 0", int_req); end
        irq_in = '0; tick();
    endtask

    task automatic test_random();
        int e_pend, e_req;
        logic [7:0] e_dout;
        for (int c = 0; c < 600; c++) begin
            RESET         = ($urandom % 80) == 0;
            DL            = 8'($urandom);
            Thingy_to_bot = ($urandom % 8) == 0;
            IF_wr         = ($urandom % 10) == 0;
            if (($urandom % 4) == 0) irq_in = 5'($urandom);
            ei            = ($urandom % 6) == 0;
            di            = ($urandom % 14) == 0;
            m1            = ($urandom % 3) == 0;
            int_ack       = ($urandom % 3) == 0;
            vec_sample    = ($urandom % 3) == 0;
            vec_taken     = ($urandom % 3) == 0;
            IE_rd         = ($urandom % 3) == 0;
            IF_rd         = ($urandom % 3) == 0;
            #1;
            e_pend = ((m_ie & m_if & 31) != 0) ? 1 : 0;
            e_req  = (m_ime != 0 && e_pend != 0 && m_stage == 0) ? 1 : 0;
            e_dout = IE_rd ? 8'(m_ie) : (IF_rd ? 8'(m_if | 'hE0) : 8'h00);
            n_cmp++; if (dout !== e_dout) begin n_bad++; $display("FAIL rnd_dout c=%0d: got %h want %h", c, dout, e_dout); end
            n_cmp++; if (dout_oe !== (IE_rd | IF_rd)) begin n_bad++; $display("FAIL rnd_oe c=%0d: got %b want %b", c, dout_oe, IE_rd | IF_rd); end
            n_cmp++; if (int_pending !== 1'(e_pend)) begin n_bad++; $display("FAIL rnd_pend c=%0d: got %b want %0d", c, int_pending, e_pend); end
            n_cmp++; if (int_req !== 1'(e_req)) begin n_bad++; $display("FAIL rnd_req c=%0d: got %b want %0d", c, int_req, e_req); end
            n_cmp++; if (vec_valid !== 1'(m_valid)) begin n_bad++; $display("FAIL rnd_valid c=%0d: got %b want %0d", c, vec_valid, m_valid); end
            n_cmp++; if (vector !== 8'(m_vec)) begin n_bad++; $display("FAIL rnd_vector c=%0d: got %h want %h", c, vector, 8'(m_vec)); end
            tick();
        end
        RESET = 0; IE_rd = 0; IF_rd = 0;
    endtask

    initial begin
        test_reset();
        test_ie_if_rw();
        test_priority();
        test_ei_delay();
        test_race();
        test_cancel();
        test_reset_in_vec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Responder side of the IE-access path. Holds the IE register, loaded from the DL bus when the CPU core flags an IE write at 0xFFFF.
- Also holds the IF register, the IME flag and the EI delay.
- Detects peripheral interrupt edges, prioritises pending interrupts and runs the dispatch handshake with the CPU sequencer.
- Supplies the RST vector (0x40/0x48/0x50/0x58/0x60) and the HALT wake signal.

Parameters:
- NUM_IRQ, 5, number of interrupt sources; bit 0 has the highest priority.
- VEC_BASE, 8'h40, vector for source 0.
- VEC_STEP, 8, vector spacing between sources.

Ports:
- CLK  input  1  core clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- DL  input  8  CPU data latch bus, write data.
- Thingy_to_bot  input  1  IE write strobe (0xFFFF access & WR); 1-cycle pulse.
- IF_wr  input  1  IF write strobe (0xFF0F access & WR).
- IE_rd  input  1  IE read select.
- IF_rd  input  1  IF read select.
- dout  output  8  read data.
- dout_oe  output  1  high while IE_rd or IF_rd is asserted.
- irq_in  input  NUM_IRQ  peripheral request levels; a rising edge sets the IF bit.
- ei  input  1  EI executed, 1-cycle pulse.
- di  input  1  DI executed, 1-cycle pulse.
- m1  input  1  instruction boundary (opcode fetch start) pulse.
- int_pending  output  1  |(IE & IF), independent of IME; used for HALT wake.
- int_req  output  1  IME & int_pending & state==IDLE.
- int_ack  input  1  CPU begins dispatch, 1-cycle pulse.
- vec_sample  input  1  CPU requests the vector (after the PC high byte is pushed).
- vector  output  8  dispatch vector, valid while vec_valid is high.
- vec_valid  output  1  vector is valid; held until vec_taken.
- vec_taken  input  1  CPU has loaded the vector into PC.

Behaviour:
- Reset values: IE=0, IF=0, IME=0, ei_dly=0, irq_prev=0, state=IDLE, vector=0, vec_valid=0. Every output is 0 during and after reset until inputs change it.
- Because irq_prev resets to 0, an irq_in held high at reset release sets its IF bit on the first cycle after reset.
- IE: loaded from DL when Thingy_to_bot=1. All 8 bits are stored and read back.
- IF per bit i, next value:
  - Base: DL[i] if IF_wr, else IF[i].
  - The clear of the dispatched bit (dispatch clear) is applied next.
  - A rising edge (irq_in[i] & ~irq_prev[i]) is applied last, so a set wins over both a write and a clear in the same cycle.
- IF bits at NUM_IRQ and above do not exist and read as 1.
- dout: IE if IE_rd; else {1s, IF} if IF_rd; else 8'h00. IE_rd has priority if both are asserted.
- IME:
  - di clears IME and ei_dly.
  - ei sets ei_dly.
  - At the next m1 with ei_dly=1: IME=1, ei_dly=0.
  - An m1 in the same cycle as ei does not promote ei_dly. IME rises at the m1 after the one following EI.
  - di and ei in the same cycle: di wins.
- Priority: lowest set index of IE&IF. Vector = VEC_BASE + idx*VEC_STEP.
- FSM states: IDLE, PUSH, VEC.
  - IDLE→PUSH on int_ack (only legal while int_req=1; int_ack at other times is ignored). IME is cleared in the same edge.
  - PUSH→VEC on vec_sample. The vector is resolved (see Optional Feature), the chosen IF bit is cleared and vec_valid=1 from the next cycle.
  - VEC→IDLE on vec_taken; vec_valid drops in the same edge.
  - int_req is forced to 0 outside IDLE.
  - ei/di remain effective in all states.
- RESET in any state returns to IDLE with all reset values; any partial dispatch is abandoned.

Optional Feature:
- Macro: IRQ_DISPATCH_CANCEL_EN.
- Defined:
  - The highest-priority index is evaluated at vec_sample, so IE/IF writes during PUSH are honoured.
  - If IE&IF==0 at vec_sample: vector=8'h00, no IF bit is cleared, vec_valid is still asserted (DMG cancel quirk).
- Undefined:
  - The index is latched at int_ack and used at vec_sample regardless of later IE/IF changes.
  - That IF bit is cleared at vec_sample, even if software already cleared it.

Test Plan:
- IE write: Thingy_to_bot with DL=8'h1F, then IE_rd → dout=8'h1F, dout_oe=1. IF_wr with DL=8'h00, then IF_rd → dout=8'hE0.
- Priority: IE=1F, IME=1, rising edges on irq_in[2] and irq_in[0] in the same cycle → IF=05, int_req=1. ack/sample/taken → vector=8'h40, IF=04, IME=0, int_req=0.
- EI delay: ei, then m1 → IME=0; second m1 → IME=1. ei+di in the same cycle → IME stays 0.
- Set-vs-clear race: dispatch of bit 2 with an irq_in[2] rising edge in the vec_sample cycle → vector=8'h50, IF[2]=1 afterwards.
- Cancel: IE=04, IF=04, int_ack, then Thingy_to_bot DL=00 during PUSH, then vec_sample.
  - With IRQ_DISPATCH_CANCEL_EN: vector=8'h00, IF=04.
  - Without: vector=8'h50, IF=00.
- RESET asserted in state VEC → next cycle vec_valid=0, IE=IF=0, IME=0, int_req=0, state IDLE.
